// File: rtl/nn_upsampler_pkg.sv
// Shared types and helpers for the nn_upsampler stream block.
// clog2 is the common ceil-log2 used to size raster counters and RAM addresses.
package nn_upsampler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/nn_upsampler_if.sv
// Pooled-sample input stream and upsampled raster output of nn_upsampler.
// The master drives the pooled samples; the slave (the upsampler) drives the raster.
interface nn_upsampler_if
  import nn_upsampler_pkg::*;
#(
  parameter int W_WIDTH    = 10,
  parameter int W_HEIGHT   = 6,
  parameter int FIXED_BITW = 8,
  parameter int UNITS      = 2
);
  localparam int H_BITW = clog2(W_WIDTH);
  localparam int V_BITW = clog2(W_HEIGHT);
  localparam int PIX_W  = FIXED_BITW * UNITS;

  logic              in_enable;
  logic [PIX_W-1:0]  in_pixels;
  logic [V_BITW-2:0] in_vcnt;
  logic [H_BITW-2:0] in_hcnt;

  logic              out_enable;
  logic [PIX_W-1:0]  out_pixels;
  logic [V_BITW-1:0] out_vcnt;
  logic [H_BITW-1:0] out_hcnt;
  logic              sync_err;

  modport master (
    output in_enable, in_pixels, in_vcnt, in_hcnt,
    input  out_enable, out_pixels, out_vcnt, out_hcnt, sync_err
  );

  modport slave (
    input  in_enable, in_pixels, in_vcnt, in_hcnt,
    output out_enable, out_pixels, out_vcnt, out_hcnt, sync_err
  );

endinterface

// File: rtl/upsample_linebuf.sv
// Simple dual-port line buffer holding one half-res row of pooled samples.
// Registered read; a same-address read and write in one cycle returns the old word.
module upsample_linebuf
  import nn_upsampler_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int BIT_WIDTH = 16,
  parameter int ADDR_W    = clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [BIT_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [BIT_WIDTH-1:0] rd_data
);

  logic [BIT_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/nn_upsampler.sv
// 2x2 nearest-neighbour upsampler: sparse pooled stream in, dense full-res raster out.
// Even rows replay the just-accepted sample; odd rows replay the line buffer.
module nn_upsampler
  import nn_upsampler_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 4,
  parameter int W_WIDTH    = 10,
  parameter int W_HEIGHT   = 6,
  parameter int FIXED_BITW = 8,
  parameter int UNITS      = 2
) (
  input logic           clock,
  input logic           n_rst,
  nn_upsampler_if.slave bus
);

  localparam int H_BITW = clog2(W_WIDTH);
  localparam int V_BITW = clog2(W_HEIGHT);
  localparam int PIX_W  = FIXED_BITW * UNITS;
  localparam int DEPTH  = WIDTH / 2;
  localparam int ADDR_W = clog2(DEPTH);

  localparam logic [H_BITW-1:0] X_LAST = H_BITW'(W_WIDTH - 1);
  localparam logic [V_BITW-1:0] Y_LAST = V_BITW'(W_HEIGHT - 1);
  localparam logic [H_BITW:0]   X_LIM  = (H_BITW + 1)'(WIDTH);
  localparam logic [V_BITW:0]   Y_LIM  = (V_BITW + 1)'(HEIGHT);

  state_t            state_reg, state_next;
  logic [V_BITW-1:0] oy_reg, y_next, adv_y;
  logic [H_BITW-1:0] ox_reg, x_next, adv_x, la_x;
  logic [PIX_W-1:0]  bypass_reg, out_pixels_reg, pix_next, rd_data;
  logic              out_enable_reg, en_next;
  logic              sync_err_reg, err_next;
  logic              accept, is_origin, aligned;
  logic [ADDR_W-1:0] rd_addr, wr_addr;

  always_comb begin
    if (ox_reg == X_LAST) begin
      adv_x = '0;
      adv_y = (oy_reg == Y_LAST) ? '0 : oy_reg + V_BITW'(1);
    end else begin
      adv_x = ox_reg + H_BITW'(1);
      adv_y = oy_reg;
    end
  end

  assign is_origin = bus.in_enable && (bus.in_vcnt == '0) && (bus.in_hcnt == '0);
  assign aligned   = ({bus.in_vcnt, 1'b0} == adv_y) && ({bus.in_hcnt, 1'b0} == adv_x);

  // A (0,0) sample is always a legal frame start, even when it arrives off-raster.
  always_comb begin
    state_next = state_reg;
    y_next     = adv_y;
    x_next     = adv_x;
    accept     = 1'b0;
    err_next   = 1'b0;
    if (state_reg == IDLE) begin
      y_next = oy_reg;
      x_next = ox_reg;
      if (is_origin) begin
        accept     = 1'b1;
        state_next = RUN;
        y_next     = '0;
        x_next     = '0;
      end
    end else if (bus.in_enable) begin
      if (aligned) begin
        accept = 1'b1;
      end else if (is_origin) begin
        accept = 1'b1;
        y_next = '0;
        x_next = '0;
      end else begin
        err_next   = 1'b1;
        state_next = IDLE;
        y_next     = oy_reg;
        x_next     = ox_reg;
      end
    end
  end

  // Read address looks one pixel ahead so RAM data lands as the odd-row pixel is due.
  assign la_x    = (x_next == X_LAST) ? '0 : x_next + H_BITW'(1);
  assign rd_addr = ADDR_W'(la_x >> 1);
  assign wr_addr = ADDR_W'(bus.in_hcnt);

  assign en_next  = (state_next == RUN) && ({1'b0, y_next} < Y_LIM) && ({1'b0, x_next} < X_LIM);
  assign pix_next = y_next[0] ? rd_data : (accept ? bus.in_pixels : bypass_reg);

  upsample_linebuf #(
    .DEPTH     (DEPTH),
    .BIT_WIDTH (PIX_W),
    .ADDR_W    (ADDR_W)
  ) u_linebuf (
    .clock   (clock),
    .wr_en   (accept),
    .wr_addr (wr_addr),
    .wr_data (bus.in_pixels),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state_reg      <= IDLE;
      oy_reg         <= '0;
      ox_reg         <= '0;
      bypass_reg     <= '0;
      out_enable_reg <= 1'b0;
      out_pixels_reg <= '0;
      sync_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      oy_reg         <= y_next;
      ox_reg         <= x_next;
      out_enable_reg <= en_next;
      sync_err_reg   <= err_next;
      if (accept) begin
        bypass_reg <= bus.in_pixels;
      end
      if (en_next) begin
        out_pixels_reg <= pix_next;
      end
    end
  end

  assign bus.out_enable = out_enable_reg;
  assign bus.out_pixels = out_pixels_reg;
  assign bus.out_vcnt   = oy_reg;
  assign bus.out_hcnt   = ox_reg;
  assign bus.sync_err   = sync_err_reg;

endmodule

// File: tb/tb_nn_upsampler.sv
// Directed/randomized bench for nn_upsampler, 8x4 image in a 10x6 frame, 2 channels of 8 bits.
// The reference tracks a linear raster index and the latest sample per half-res pixel.
module tb_nn_upsampler;

  localparam int WIDTH      = 8;
  localparam int HEIGHT     = 4;
  localparam int W_WIDTH    = 10;
  localparam int W_HEIGHT   = 6;
  localparam int FIXED_BITW = 8;
  localparam int UNITS      = 2;
  localparam int PIX_W      = FIXED_BITW * UNITS;
  localparam int V_BITW     = 3;
  localparam int H_BITW     = 4;
  localparam int FRAME      = W_WIDTH * W_HEIGHT;

  logic clock;
  logic n_rst;

  nn_upsampler_if #(
    .W_WIDTH    (W_WIDTH),
    .W_HEIGHT   (W_HEIGHT),
    .FIXED_BITW (FIXED_BITW),
    .UNITS      (UNITS)
  ) bus ();

  nn_upsampler #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .W_WIDTH    (W_WIDTH),
    .W_HEIGHT   (W_HEIGHT),
    .FIXED_BITW (FIXED_BITW),
    .UNITS      (UNITS)
  ) dut (
    .clock (clock),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks;
  int errors;

  // reference state
  bit               m_run;
  int               m_pos;
  logic [PIX_W-1:0] m_pix;
  logic [PIX_W-1:0] samp [HEIGHT/2][WIDTH/2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_pos = 0;
    m_pix = '0;
  endtask

  function automatic logic [PIX_W-1:0] make_pix(input int mode, input int i, input int j);
    logic [7:0] v;
    v = 8'(16 * i + j);
    case (mode)
      0:       return {v, v};
      1:       return ((i + j) % 2 == 1) ? 16'hFF80 : 16'h80FF;
      default: return PIX_W'($urandom);
    endcase
  endfunction

  // One clock: present a sample (or nothing), predict, then check all outputs.
  task automatic cycle(input bit en, input int i, input int j, input logic [PIX_W-1:0] pix);
    int  nxt;
    int  y;
    int  x;
    bit  acc;
    bit  err;
    bit  exp_en;
    bus.in_enable = en;
    bus.in_vcnt   = (V_BITW - 1)'(i);
    bus.in_hcnt   = (H_BITW - 1)'(j);
    bus.in_pixels = pix;
    acc = 1'b0;
    err = 1'b0;
    nxt = m_pos;
    if (!m_run) begin
      if (en && i == 0 && j == 0) begin
        m_run = 1'b1;
        nxt   = 0;
        acc   = 1'b1;
      end
    end else begin
      nxt = (m_pos + 1) % FRAME;
      if (en) begin
        if (2 * i == nxt / W_WIDTH && 2 * j == nxt % W_WIDTH) begin
          acc = 1'b1;
        end else if (i == 0 && j == 0) begin
          acc = 1'b1;
          nxt = 0;
        end else begin
          err   = 1'b1;
          m_run = 1'b0;
          nxt   = m_pos;
        end
      end
    end
    m_pos = nxt;
    if (acc) samp[i][j] = pix;
    y = m_pos / W_WIDTH;
    x = m_pos % W_WIDTH;
    exp_en = m_run && (y < HEIGHT) && (x < WIDTH);
    if (exp_en) m_pix = samp[y / 2][x / 2];
    if (en) $display("in (%0d,%0d) data %h -> %s", i, j, pix,
                     acc ? "accepted" : (err ? "sync_err" : "ignored"));
    @(posedge clock);
    #1;
    chk("out_enable", 32'(bus.out_enable), 32'(exp_en));
    chk("sync_err", 32'(bus.sync_err), 32'(err));
    chk("out_pixels", 32'(bus.out_pixels), 32'(m_pix));
    chk("out_vcnt", 32'(bus.out_vcnt), 32'(y));
    chk("out_hcnt", 32'(bus.out_hcnt), 32'(x));
    bus.in_enable = 1'b0;
  endtask

  // Feed one frame at max-pool timing; optional injected sample and early stop.
  task automatic feed_frame(input int mode, input int inj_k, input int stop_k);
    int               y;
    int               x;
    int               i;
    int               j;
    bit               en;
    logic [PIX_W-1:0] p;
    for (int k = 0; k < FRAME; k++) begin
      if (k == stop_k) return;
      y  = k / W_WIDTH;
      x  = k % W_WIDTH;
      en = 1'b0;
      i  = 0;
      j  = 0;
      p  = '0;
      if (y % 2 == 0 && y < HEIGHT && x % 2 == 0 && x < WIDTH) begin
        en = 1'b1;
        i  = y / 2;
        j  = x / 2;
        p  = make_pix(mode, i, j);
      end
      if (k == inj_k) begin
        en = 1'b1;
        i  = 1;
        j  = 3;
        p  = make_pix(2, 1, 3);
      end
      cycle(en, i, j, p);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_enable"}, 32'(bus.out_enable), 32'(0));
    chk({tag, "_sync_err"}, 32'(bus.sync_err), 32'(0));
    chk({tag, "_pixels"}, 32'(bus.out_pixels), 32'(0));
    chk({tag, "_vcnt"}, 32'(bus.out_vcnt), 32'(0));
    chk({tag, "_hcnt"}, 32'(bus.out_hcnt), 32'(0));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_rst = 1'b0;
    bus.in_enable = 1'b0;
    bus.in_pixels = '0;
    bus.in_vcnt   = '0;
    bus.in_hcnt   = '0;
    model_reset();
    for (int a = 0; a < HEIGHT / 2; a++)
      for (int b = 0; b < WIDTH / 2; b++)
        samp[a][b] = '0;

    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("reset");
    @(negedge clock);
    n_rst = 1'b1;

    // stray samples before the first frame start are ignored
    cycle(1'b1, 0, 1, make_pix(2, 0, 1));
    cycle(1'b1, 1, 0, make_pix(2, 1, 0));
    cycle(1'b0, 0, 0, '0);
    cycle(1'b1, 1, 3, make_pix(2, 1, 3));

    // ramp, negative values, then two random frames, all back-to-back
    feed_frame(0, -1, -1);
    feed_frame(1, -1, -1);
    feed_frame(2, -1, -1);
    feed_frame(2, -1, -1);

    // extra off-raster sample, then resume at the next frame start
    feed_frame(2, 3, -1);
    feed_frame(2, -1, -1);

    // reset in the middle of row 3, then a clean frame
    feed_frame(2, -1, 3 * W_WIDTH + 4);
    n_rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    model_reset();
    @(negedge clock);
    n_rst = 1'b1;
    feed_frame(0, -1, -1);
    feed_frame(2, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
